// File: rtl/prescaled_digit_counter_if.sv
// Control/status bundle for prescaled_digit_counter: count controls in, digit vector and strobes out.
// The master side drives the controls; the slave side is the counter itself.
interface prescaled_digit_counter_if #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned DIGIT_W = 4
) ();

  logic                        en;
  logic                        up_dn;
  logic                        clr;
  logic                        load;
  logic [DIGITS*DIGIT_W-1:0]   load_val;
  logic [DIGITS*DIGIT_W-1:0]   count;
  logic                        tick;
  logic                        carry_out;

  modport master (
    output en, up_dn, clr, load, load_val,
    input  count, tick, carry_out
  );

  modport slave (
    input  en, up_dn, clr, load, load_val,
    output count, tick, carry_out
  );

endinterface

// File: rtl/prescaled_digit_counter.sv
// Cascaded modulo-N digit counter stepped once every PRESCALE enabled clocks.
// Supports up/down, synchronous clear/load (load saturates digits), and registered tick/carry strobes.
module prescaled_digit_counter #(
  parameter int unsigned PRESCALE = 30,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned DIGIT_W  = 4,
  parameter int unsigned MODULO   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  prescaled_digit_counter_if.slave  bus
);

  localparam int unsigned CW = DIGITS * DIGIT_W;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]      PresMax = PW'(PRESCALE - 1);
  localparam logic [DIGIT_W-1:0] DigMax  = DIGIT_W'(MODULO - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] count_q, count_d;
  logic          tick_q, tick_d;
  logic          carry_q, carry_d;

  logic               step;
  logic [CW-1:0]      stepped;
  logic [CW-1:0]      loaded;
  logic               ripple;
  logic [DIGIT_W-1:0] dig;
  logic [DIGIT_W-1:0] dig_l;

  assign step = bus.en && (presc_q == PresMax);

  // Ripple carry/borrow: ripple stays set only while every lower digit wrapped.
  always_comb begin
    stepped = count_q;
    ripple  = 1'b1;
    dig     = '0;
    for (int k = 0; k < DIGITS; k++) begin
      dig = count_q[k*DIGIT_W +: DIGIT_W];
      if (ripple) begin
        if (bus.up_dn) begin
          if (dig == DigMax) begin
            stepped[k*DIGIT_W +: DIGIT_W] = '0;
          end else begin
            stepped[k*DIGIT_W +: DIGIT_W] = dig + DIGIT_W'(1);
            ripple = 1'b0;
          end
        end else begin
          if (dig == '0) begin
            stepped[k*DIGIT_W +: DIGIT_W] = DigMax;
          end else begin
            stepped[k*DIGIT_W +: DIGIT_W] = dig - DIGIT_W'(1);
            ripple = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    loaded = '0;
    dig_l  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      dig_l = bus.load_val[k*DIGIT_W +: DIGIT_W];
      loaded[k*DIGIT_W +: DIGIT_W] = (32'(dig_l) >= MODULO) ? DigMax : dig_l;
    end
  end

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    if (bus.clr) begin
      presc_d = '0;
      count_d = '0;
    end else begin
      if (bus.en) begin
        presc_d = step ? '0 : presc_q + PW'(1);
      end
      // A load swallows a coincident step, so no strobes for it.
      if (bus.load) begin
        count_d = loaded;
      end else if (step) begin
        count_d = stepped;
        tick_d  = 1'b1;
        carry_d = ripple;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.tick      = tick_q;
  assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_prescaled_digit_counter.sv
// Bench for prescaled_digit_counter: three instances (P30/hex, P1/hex, P1/BCD) share stimulus and
// are compared every cycle against an arithmetic model that treats the count as a base-MODULO number.
module tb_prescaled_digit_counter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc_n    = 0;

  prescaled_digit_counter_if #(.DIGITS(4), .DIGIT_W(4)) if_a ();
  prescaled_digit_counter_if #(.DIGITS(4), .DIGIT_W(4)) if_b ();
  prescaled_digit_counter_if #(.DIGITS(4), .DIGIT_W(4)) if_c ();

  prescaled_digit_counter #(.PRESCALE(30), .DIGITS(4), .DIGIT_W(4), .MODULO(16)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );
  prescaled_digit_counter #(.PRESCALE(1), .DIGITS(4), .DIGIT_W(4), .MODULO(16)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );
  prescaled_digit_counter #(.PRESCALE(1), .DIGITS(4), .DIGIT_W(4), .MODULO(10)) u_dut_c (
    .clk (clk),
    .rst (rst),
    .bus (if_c.slave)
  );

  // Model state: prescaler phase, count as an integer, expected strobes.
  int unsigned m_presc [3];
  longint      m_val   [3];
  bit          m_tick  [3];
  bit          m_carry [3];

  function automatic int unsigned ps_of(int i);
    return (i == 0) ? 30 : 1;
  endfunction

  function automatic int unsigned md_of(int i);
    return (i == 2) ? 10 : 16;
  endfunction

  function automatic longint span_of(int i);
    longint s = 1;
    for (int k = 0; k < 4; k++) s = s * longint'(md_of(i));
    return s;
  endfunction

  function automatic logic [15:0] to_vec(longint v, int unsigned m);
    logic [15:0] r = '0;
    longint      x = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(x % longint'(m));
      x = x / longint'(m);
    end
    return r;
  endfunction

  function automatic longint sat_val(logic [15:0] lv, int unsigned m);
    longint v = 0;
    longint d;
    for (int k = 3; k >= 0; k--) begin
      d = longint'(lv[4*k +: 4]);
      if (d >= longint'(m)) d = longint'(m) - 1;
      v = v * longint'(m) + d;
    end
    return v;
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_presc[i] = 0;
      m_val[i]   = 0;
      m_tick[i]  = 1'b0;
      m_carry[i] = 1'b0;
    end
  endtask

  task automatic model_update(int i, bit e, bit u, bit cl, bit l, logic [15:0] lv);
    bit     stp;
    longint span = span_of(i);
    m_tick[i]  = 1'b0;
    m_carry[i] = 1'b0;
    if (cl) begin
      m_presc[i] = 0;
      m_val[i]   = 0;
    end else begin
      stp = e && (m_presc[i] == ps_of(i) - 1);
      if (e) m_presc[i] = stp ? 0 : m_presc[i] + 1;
      if (l) begin
        m_val[i] = sat_val(lv, md_of(i));
      end else if (stp) begin
        m_tick[i] = 1'b1;
        if (u) begin
          m_carry[i] = (m_val[i] == span - 1);
          m_val[i]   = (m_val[i] + 1) % span;
        end else begin
          m_carry[i] = (m_val[i] == 0);
          m_val[i]   = (m_val[i] + span - 1) % span;
        end
      end
    end
  endtask

  task automatic check_inst(int i, logic [15:0] cnt, logic tk, logic cy);
    check_eq($sformatf("inst%0d cyc%0d count", i, cyc_n), 32'(cnt), 32'(to_vec(m_val[i], md_of(i))));
    check_eq($sformatf("inst%0d cyc%0d tick", i, cyc_n), 32'(tk), 32'(m_tick[i]));
    check_eq($sformatf("inst%0d cyc%0d carry", i, cyc_n), 32'(cy), 32'(m_carry[i]));
  endtask

  task automatic check_all();
    check_inst(0, if_a.count, if_a.tick, if_a.carry_out);
    check_inst(1, if_b.count, if_b.tick, if_b.carry_out);
    check_inst(2, if_c.count, if_c.tick, if_c.carry_out);
  endtask

  task automatic drive(bit e, bit u, bit cl, bit l, logic [15:0] lv);
    if_a.en = e;  if_a.up_dn = u;  if_a.clr = cl;  if_a.load = l;  if_a.load_val = lv;
    if_b.en = e;  if_b.up_dn = u;  if_b.clr = cl;  if_b.load = l;  if_b.load_val = lv;
    if_c.en = e;  if_c.up_dn = u;  if_c.clr = cl;  if_c.load = l;  if_c.load_val = lv;
  endtask

  // Called at a negedge: apply inputs, advance the model, sample after the next posedge.
  task automatic run_cycle(bit e, bit u, bit cl, bit l, logic [15:0] lv);
    drive(e, u, cl, l, lv);
    for (int i = 0; i < 3; i++) model_update(i, e, u, cl, l, lv);
    @(negedge clk);
    cyc_n++;
    check_all();
  endtask

  initial begin
    bit          e, u, cl, l;
    logic [15:0] lv;

    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Free-running up count at the prescaled rate.
    repeat (100) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("t1 a count", 32'(if_a.count), 32'h0003);
    check_eq("t1 c count", 32'(if_c.count), 32'h0100);

    // Full-chain wrap up.
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFE);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("t2 b wrap count", 32'(if_b.count), 32'h0000);
    check_eq("t2 b wrap carry", 32'(if_b.carry_out), 32'h1);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("t2 b after carry", 32'(if_b.carry_out), 32'h0);

    // BCD ripple and load saturation.
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0099);
    repeat (2) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("t3 c bcd ripple", 32'(if_c.count), 32'h0101);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h00AF);
    check_eq("t3 c saturate", 32'(if_c.count), 32'h0099);

    // BCD borrow wrap down.
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_eq("t4 c down wrap", 32'(if_c.count), 32'h9999);
    check_eq("t4 c down carry", 32'(if_c.carry_out), 32'h1);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_eq("t4 c down next", 32'(if_c.count), 32'h9998);

    // Enable gap mid-period, then clr+load and load alone on a step edge of instance A.
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    repeat (15) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (10) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (20) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 40 && m_presc[0] != 29; k++) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
    check_eq("t5 clr+load count", 32'(if_a.count), 32'h0000);
    check_eq("t5 clr+load tick", 32'(if_a.tick), 32'h0);
    for (int k = 0; k < 40 && m_presc[0] != 29; k++) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h0042);
    check_eq("t5 load on step", 32'(if_a.count), 32'h0042);
    check_eq("t5 load no tick", 32'(if_a.tick), 32'h0);

    // Randomised traffic, biased toward wrap-prone load values.
    u = 1'b1;
    repeat (3000) begin
      e  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) u = ~u;
      cl = ($urandom_range(0, 99) == 0);
      l  = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       lv = 16'hFFFF;
        1:       lv = 16'h0000;
        2:       lv = 16'h9999;
        default: lv = 16'($urandom);
      endcase
      run_cycle(e, u, cl, l, lv);
    end

    // Asynchronous reset between edges while strobes are high.
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    #2 rst = 1'b1;
    #1;
    check_eq("t6 a count async", 32'(if_a.count), 32'h0000);
    check_eq("t6 b count async", 32'(if_b.count), 32'h0000);
    check_eq("t6 b tick async", 32'(if_b.tick), 32'h0);
    check_eq("t6 b carry async", 32'(if_b.carry_out), 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (35) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("t6 a first tick", 32'(if_a.count), 32'h0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/prescaled_digit_counter.md
Name: prescaled_digit_counter

Overview:
Parametrised multi-digit counter driven by an internal prescaler. It advances a cascaded chain of digits once every PRESCALE enabled clock cycles. Each digit has a selectable modulo (16 gives hex, 10 gives BCD). The block adds up/down counting, synchronous load and clear, an enable, and tick/carry strobes, and is the standard display/timebase counter for board-level designs.

Parameters:
PRESCALE, 30, enabled clocks per count step; legal range 1..2^24.
DIGITS, 4, number of cascaded digits; legal range 1..8.
DIGIT_W, 4, bits per digit.
MODULO, 16, per-digit wrap value; legal range 2..2^DIGIT_W.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
en  in  1  count enable; gates the prescaler.
up_dn  in  1  1 = count up, 0 = count down; sampled on the step cycle.
clr  in  1  synchronous clear of the count and the prescaler.
load  in  1  synchronous load of load_val into the count.
load_val  in  DIGITS*DIGIT_W  load value; digit 0 occupies the LSBs.
count  out  DIGITS*DIGIT_W  current digit vector; digit 0 occupies the LSBs.
tick  out  1  registered one-cycle pulse on each count step.
carry_out  out  1  registered one-cycle pulse when the whole chain wraps.

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately): prescaler=0, count=0, tick=0, carry_out=0. The block holds this state while rst is high and resumes on the first clk edge after rst falls.
- Prescaler: width is clog2(PRESCALE), minimum 1 bit.
  - en=1: increments each cycle, 0..PRESCALE-1, then wraps to 0. The period is exactly PRESCALE cycles.
  - en=0: holds its value.
  - A step occurs on the edge where en=1 and prescaler==PRESCALE-1.
  - With PRESCALE=1, every enabled cycle is a step.
- Step, up direction:
  - Digit 0 increments.
  - Digit k increments only if digits 0..k-1 all equal MODULO-1.
  - A digit at MODULO-1 that increments wraps to 0.
- Step, down direction:
  - Digit 0 decrements.
  - Digit k decrements only if digits 0..k-1 all equal 0.
  - A digit at 0 that decrements wraps to MODULO-1.
- The whole carry/borrow ripple resolves in the same cycle; count is updated on the step edge.
- tick=1 for exactly the cycle following each step edge, and only if that step actually updated count.
- carry_out=1 in the same cycle as tick when the step wrapped every digit:
  - up: from all MODULO-1 to all 0;
  - down: from all 0 to all MODULO-1.
- Priority, highest first: clr > load > step.
  - clr: count=0, prescaler=0. tick and carry_out are 0 next cycle.
  - load: count takes load_val. The prescaler keeps running if en=1. A step coinciding with load is discarded, and tick and carry_out are 0 next cycle.
  - load_val digits >= MODULO saturate to MODULO-1 on load.
- up_dn may change on any cycle; only its value on the step edge matters. No hysteresis.
- en has no effect on clr or load.
- No combinational path from any input to any output.

Test Plan:
1. Defaults, rst pulse then en=1, up_dn=1 for 100 cycles -> tick pulses at cycles 30, 60, 90 after release; count reads 0x0001, 0x0002, 0x0003; carry_out stays 0.
2. PRESCALE=1, load 0xFFFE then en=1, up -> count 0xFFFF, then 0x0000 with carry_out=1 and tick=1 in the same cycle, then 0x0001 with carry_out=0.
3. MODULO=10, PRESCALE=1, load 0x0099, up for 2 steps -> count 0x0100, then 0x0101. Loading 0x00AF stores 0x0099 (saturation).
4. PRESCALE=1, MODULO=10, count 0x0000, up_dn=0, one step -> count 0x9999 with carry_out=1. Next step -> 0x9998.
5. Defaults, en toggled 0 for 10 cycles mid-period -> tick is delayed by exactly 10 cycles. clr and load asserted together on a step edge -> count 0, prescaler 0, tick 0.
6. rst asserted mid-period between clock edges -> count, tick and carry_out go to 0 before the next edge. After release, the first tick comes exactly PRESCALE enabled cycles later.
